cla_slice_sequencer: RTL and testbench



---
 rtl/cla_slice_sequencer_if.sv | 39 +++
 rtl/cla_slice_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cla_slice_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cla_slice_sequencer_if.sv
// Operand/result handshake bundle for cla_slice_sequencer.
// Optional macro CLA_SLICE_SIGNED_OVF_EN adds the out_ovf result flag.
interface cla_slice_sequencer_if #(
  parameter int NUM_SLICES = 4,
  parameter int SLICE_W    = 9
);
  localparam int W = SLICE_W * NUM_SLICES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CLA_SLICE_SIGNED_OVF_EN
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/cla_slice_sequencer.sv
// Multi-precision adder: streams wide operands through one 9-bit cla_adder, LSB slice first.
// Optional macro CLA_SLICE_SIGNED_OVF_EN adds a two's-complement overflow flag (out_ovf).

module cla_adder (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       cin,
  output logic [8:0] s,
  output logic       cout
);
  logic [8:0] g;
  logic [8:0] p;
  logic [9:0] c;

  // Flattened lookahead: carry n = OR of each lower generate propagated up, plus propagated cin.
  function automatic logic carry_into(input logic [8:0] gv, input logic [8:0] pv,
                                      input logic ci, input int n);
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc  = acc | (prop & gv[j]);
      prop = prop & pv[j];
    end
    return acc | (prop & ci);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_bit
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
      assign s[gi] = p[gi] ^ c[gi];
    end
    for (gi = 0; gi < 10; gi++) begin : g_carry
      assign c[gi] = carry_into(g, p, cin, gi);
    end
  endgenerate

  assign cout = c[9];
endmodule

module cla_slice_sequencer #(
  parameter int NUM_SLICES = 4,
  parameter int SLICE_W    = 9
) (
  input logic                    clk,
  input logic                    rst,
  cla_slice_sequencer_if.slave   bus
);
  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = $clog2(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (SLICE_W != 9) begin : g_bad_slice_w
      $error("cla_slice_sequencer: SLICE_W must be 9 to match cla_adder");
    end
    if (NUM_SLICES < 2 || NUM_SLICES > 16) begin : g_bad_num_slices
      $error("cla_slice_sequencer: NUM_SLICES must be within 2..16");
    end
  endgenerate

  logic [1:0]         state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       sum_reg;
  logic               carry_reg;
  logic               cout_reg;

  logic [SLICE_W-1:0] a_slice [NUM_SLICES];
  logic [SLICE_W-1:0] b_slice [NUM_SLICES];
  logic [SLICE_W-1:0] cur_a;
  logic [SLICE_W-1:0] cur_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign cur_a = a_slice[idx_reg];
  assign cur_b = b_slice[idx_reg];

  cla_adder u_cla_adder (
    .a    (cur_a),
    .b    (cur_b),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign accept = (state_reg == IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
            idx_reg   <= '0;
            state_reg <= ADD;
          end
        end
        ADD: begin
          sum_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_s;
          carry_reg <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= slice_cout;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CLA_SLICE_SIGNED_OVF_EN
  logic ovf_reg;
  logic msb_carry_in;

  // Carry into the top bit falls out of its sum: c = a ^ b ^ s.
  assign msb_carry_in = a_reg[W-1] ^ b_reg[W-1] ^ slice_s[SLICE_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ADD && idx_reg == LAST_IDX) begin
      ovf_reg <= msb_carry_in ^ slice_cout;
    end
  end

  assign bus.out_ovf = ovf_reg;
`endif

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Scoreboard bench for cla_slice_sequencer (NUM_SLICES=4, W=36).
module tb_cla_slice_sequencer;
  localparam int NS = 4;
  localparam int W  = 9 * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_slice_sequencer_if #(.NUM_SLICES(NS)) bus ();

  cla_slice_sequencer #(.NUM_SLICES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    exp_t r;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Called at posedge+#1; returns at accept edge +#1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit push);
    int k = 0;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_cin   = ~cin;
    if (push) sb.push_back(model(a, b, cin));
    check("in_ready_in_add", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic collect(input int hold);
    int   n = 0;
    exp_t e;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(NS));
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    $display("result sum=0x%09h cout=%0b (exp 0x%09h %0b)", bus.out_sum, bus.out_cout, e.sum, e.cout);
    check("sum", 64'(bus.out_sum), 64'(e.sum));
    check("cout", 64'(bus.out_cout), 64'(e.cout));
`ifdef CLA_SLICE_SIGNED_OVF_EN
    check("ovf", 64'(bus.out_ovf), 64'(e.ovf));
`endif
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 36'(($urandom() << 4) ^ i);
        bus.in_b     = 36'($urandom());
        bus.in_cin   = 1'b1;
        @(posedge clk); #1;
        check("bp_sum", 64'(bus.out_sum), 64'(e.sum));
        check("bp_cout", 64'(bus.out_cout), 64'(e.cout));
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("hs_valid_drop", 64'(bus.out_valid), 64'd0);
    check("hs_idle", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("rst_out_cout", 64'(bus.out_cout), 64'd0);

    send(36'h0_0000_0005, 36'h0_0000_0003, 1'b0, 1'b1); collect(0);
    send(36'hF_FFFF_FFFF, 36'h0_0000_0000, 1'b1, 1'b1); collect(0);
    send(36'h0_0000_01FF, 36'h0_0000_0001, 1'b0, 1'b1); collect(0);
    send(36'h1_2345_6789, 36'h0_FEDC_BA98, 1'b1, 1'b1); collect(5);
    // Accepted right after the backpressured handshake.
    send(36'h0_0003_FE00, 36'h0_0000_0200, 1'b0, 1'b1); collect(0);

    // Reset during the second ADD cycle.
    send(36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_sum", 64'(bus.out_sum), 64'd0);
    send(36'h1, 36'h1, 1'b0, 1'b1); collect(0);

    send(36'h7_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b1); collect(0);
    send(36'hF_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b1); collect(0);
    send(36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 1'b1); collect(0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = 36'({$urandom(), $urandom()});
      rb = 36'({$urandom(), $urandom()});
      send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      collect(i % 3);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
